// File: rtl/mbc1_mapper_if.sv
// CPU-side bus between the Game Boy core and the MBC1 mapper.
// The mapped ROM/EXTRAM addresses and chip selects come back on the same bundle.
interface mbc1_mapper_if #(
   parameter int rom_addr_width = 19,
   parameter int ram_addr_width = 15
);
   logic [15:0]               addr;
   logic [7:0]                data_w;
   logic                      write_enable;
   logic [rom_addr_width-1:0] rom_addr;
   logic                      rom_cs;
   logic [ram_addr_width-1:0] ram_addr;
   logic                      ram_cs;
   logic                      ram_we;
   logic                      data_active;

   modport master (
      output addr,
      output data_w,
      output write_enable,
      input  rom_addr,
      input  rom_cs,
      input  ram_addr,
      input  ram_cs,
      input  ram_we,
      input  data_active
   );

   modport slave (
      input  addr,
      input  data_w,
      input  write_enable,
      output rom_addr,
      output rom_cs,
      output ram_addr,
      output ram_cs,
      output ram_we,
      output data_active
   );
endinterface

// File: rtl/mbc1_mapper.sv
// MBC1 bank controller: CPU writes below 8000 program the bank registers, and the
// ROM/EXTRAM address maps are purely combinational so the array sees them this cycle.
module mbc1_mapper #(
   parameter int rom_addr_width = 19,
   parameter int ram_addr_width = 15
) (
   input logic          clk,
   input logic          reset_n,
   mbc1_mapper_if.slave bus
);
   localparam int ROM_FULL_W = 21;
   localparam int RAM_FULL_W = 15;

   logic       ram_enable_q, ram_enable_d;
   logic [4:0] bank_lo_q, bank_lo_d;
   logic [1:0] bank_hi_q, bank_hi_d;
   logic       mode_q, mode_d;
   logic       wr_prev_q, wr_prev_d;

   logic       wr_pulse;
   logic       ctrl_write;
   logic [4:0] bank_lo_eff;
   logic [6:0] rom_bank;
   logic [1:0] ram_bank;
   logic [ROM_FULL_W-1:0] rom_full;
   logic [RAM_FULL_W-1:0] ram_full;
   logic       ram_window;
   logic       unused_bits;

   // Only the rising edge of the strobe counts, so a held write lands exactly once.
   assign wr_pulse   = bus.write_enable & ~wr_prev_q;
   assign ctrl_write = wr_pulse & ~bus.addr[15];

   always_comb begin
      ram_enable_d = ram_enable_q;
      bank_lo_d    = bank_lo_q;
      bank_hi_d    = bank_hi_q;
      mode_d       = mode_q;
      wr_prev_d    = bus.write_enable;
      if (ctrl_write) begin
         case (bus.addr[14:13])
            2'b00:   ram_enable_d = (bus.data_w[3:0] == 4'hA);
            2'b01:   bank_lo_d    = bus.data_w[4:0];
            2'b10:   bank_hi_d    = bus.data_w[1:0];
            default: mode_d       = bus.data_w[0];
         endcase
      end
   end

   // wr_prev resets high so a write still held when reset releases is not taken.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ram_enable_q <= 1'b0;
         bank_lo_q    <= 5'd0;
         bank_hi_q    <= 2'd0;
         mode_q       <= 1'b0;
         wr_prev_q    <= 1'b1;
      end else begin
         ram_enable_q <= ram_enable_d;
         bank_lo_q    <= bank_lo_d;
         bank_hi_q    <= bank_hi_d;
         mode_q       <= mode_d;
         wr_prev_q    <= wr_prev_d;
      end
   end

   // Bank 0 is never selectable in the switchable window; the zero test covers all
   // five low bits, so 20/40/60 become 21/41/61.
   always_comb begin
      bank_lo_eff = (bank_lo_q == 5'd0) ? 5'd1 : bank_lo_q;
      if (bus.addr[14])
         rom_bank = {bank_hi_q, bank_lo_eff};
      else
         rom_bank = mode_q ? {bank_hi_q, 5'b00000} : 7'd0;
      ram_bank = mode_q ? bank_hi_q : 2'd0;
      rom_full = {rom_bank, bus.addr[13:0]};
      ram_full = {ram_bank, bus.addr[12:0]};
   end

   genvar gi;
   generate
      for (gi = 0; gi < rom_addr_width; gi++) begin : g_rom_bit
         if (gi < ROM_FULL_W) begin : g_map
            assign bus.rom_addr[gi] = rom_full[gi];
         end else begin : g_pad
            assign bus.rom_addr[gi] = 1'b0;
         end
      end
      for (gi = 0; gi < ram_addr_width; gi++) begin : g_ram_bit
         if (gi < RAM_FULL_W) begin : g_map
            assign bus.ram_addr[gi] = ram_full[gi];
         end else begin : g_pad
            assign bus.ram_addr[gi] = 1'b0;
         end
      end
   endgenerate

   // Bank bits above the array size and data bits 7:5 are intentionally dropped.
   assign unused_bits = ^{rom_full, ram_full, bus.data_w[7:5]};

   assign ram_window      = (bus.addr[15:13] == 3'b101);
   assign bus.rom_cs      = ~bus.addr[15] & ~bus.write_enable;
   assign bus.ram_cs      = ram_window & ram_enable_q;
   assign bus.ram_we      = bus.ram_cs & bus.write_enable;
   assign bus.data_active = ~bus.write_enable & (bus.rom_cs | bus.ram_cs);
endmodule

// File: tb/tb_mbc1_mapper.sv
// Directed bench for mbc1_mapper: stimulus pushes hand-computed expectations into a
// scoreboard queue, and a negedge monitor pops and compares them against the outputs.
module tb_mbc1_mapper;
   localparam int ROM_W = 19;
   localparam int RAM_W = 15;

   typedef struct {
      string name;
      int    rom_addr;   // -1: not checked (address outside ROM window)
      logic  rom_cs;
      int    ram_addr;
      logic  ram_cs;
      logic  ram_we;
      logic  data_active;
   } exp_t;

   logic clk = 1'b0;
   logic reset_n;
   int   tests = 0;
   int   fails = 0;
   exp_t sb[$];

   mbc1_mapper_if #(.rom_addr_width(ROM_W), .ram_addr_width(RAM_W)) bus ();

   mbc1_mapper #(.rom_addr_width(ROM_W), .ram_addr_width(RAM_W)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_now(input string name, input int ra, input logic rcs, input int ma,
                             input logic mcs, input logic mwe, input logic da);
      exp_t e;
      e.name = name; e.rom_addr = ra; e.rom_cs = rcs; e.ram_addr = ma;
      e.ram_cs = mcs; e.ram_we = mwe; e.data_active = da;
      sb.push_back(e);
   endtask

   task automatic rd(input string name, input logic [15:0] a, input int ra, input logic rcs,
                     input int ma, input logic mcs, input logic mwe, input logic da);
      bus.addr = a;
      bus.write_enable = 1'b0;
      expect_now(name, ra, rcs, ma, mcs, mwe, da);
      step();
   endtask

   task automatic wr(input logic [15:0] a, input logic [7:0] d);
      bus.addr = a;
      bus.data_w = d;
      bus.write_enable = 1'b1;
      step();
      bus.write_enable = 1'b0;
      step();
   endtask

   // Same as wr, but also checks the outputs during the write cycle itself.
   task automatic wr_chk(input string name, input logic [15:0] a, input logic [7:0] d,
                         input int ra, input logic rcs, input int ma, input logic mcs,
                         input logic mwe, input logic da);
      bus.addr = a;
      bus.data_w = d;
      bus.write_enable = 1'b1;
      expect_now(name, ra, rcs, ma, mcs, mwe, da);
      step();
      bus.write_enable = 1'b0;
      step();
   endtask

   initial begin : monitor
      exp_t e;
      int act_rom, act_ram;
      bit bad;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            act_rom = 32'(bus.rom_addr);
            act_ram = 32'(bus.ram_addr);
            bad = 1'b0;
            if (e.rom_addr >= 0 && act_rom != e.rom_addr) bad = 1'b1;
            if (bus.rom_cs !== e.rom_cs) bad = 1'b1;
            if (act_ram != e.ram_addr) bad = 1'b1;
            if (bus.ram_cs !== e.ram_cs || bus.ram_we !== e.ram_we) bad = 1'b1;
            if (bus.data_active !== e.data_active) bad = 1'b1;
            tests++;
            if (bad) begin
               fails++;
               $display("FAIL %s: got rom=%05h cs=%0b ram=%04h cs=%0b we=%0b da=%0b, expected rom=%05h cs=%0b ram=%04h cs=%0b we=%0b da=%0b",
                        e.name, act_rom, bus.rom_cs, act_ram, bus.ram_cs, bus.ram_we, bus.data_active,
                        e.rom_addr, e.rom_cs, e.ram_addr, e.ram_cs, e.ram_we, e.data_active);
            end else begin
               $display("[TB] ok %s: rom=%05h cs=%0b ram=%04h cs=%0b we=%0b da=%0b",
                        e.name, act_rom, bus.rom_cs, act_ram, bus.ram_cs, bus.ram_we, bus.data_active);
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      reset_n = 1'b0;
      bus.addr = 16'h4000;
      bus.data_w = 8'h00;
      bus.write_enable = 1'b0;
      step();
      expect_now("reset_read_4000", 32'h04000, 1, 32'h0000, 0, 0, 1);
      step();
      reset_n = 1'b1;

      rd("read_0123", 16'h0123, 32'h00123, 1, 32'h0123, 0, 0, 1);
      wr_chk("write_cycle_2000", 16'h2000, 8'h00, 32'h02000, 0, 32'h0000, 0, 0, 0);
      rd("lo0_maps_bank1", 16'h4000, 32'h04000, 1, 32'h0000, 0, 0, 1);
      wr(16'h2000, 8'h05);
      rd("bank5", 16'h4000, 32'h14000, 1, 32'h0000, 0, 0, 1);
      wr(16'h4000, 8'h01);
      rd("bank25_trunc", 16'h4000, 32'h14000, 1, 32'h0000, 0, 0, 1);
      rd("bank25_4abc", 16'h4ABC, 32'h14ABC, 1, 32'h0ABC, 0, 0, 1);
      wr(16'h2000, 8'hE7);
      rd("lo_upper_bits_ignored", 16'h4000, 32'h1C000, 1, 32'h0000, 0, 0, 1);
      wr(16'h4000, 8'h02);
      wr(16'h2000, 8'h20);
      rd("lo20_maps_41", 16'h4000, 32'h04000, 1, 32'h0000, 0, 0, 1);
      rd("read_7fff", 16'h7FFF, 32'h07FFF, 1, 32'h1FFF, 0, 0, 1);
      wr(16'h6000, 8'h01);
      rd("mode1_read_0010", 16'h0010, 32'h00010, 1, 32'h4010, 0, 0, 1);
      rd("ram_disabled_a000", 16'hA000, -1, 0, 32'h4000, 0, 0, 0);

      wr(16'h6000, 8'h00);
      wr(16'h0000, 8'h0A);
      wr_chk("ram_write_a005", 16'hA005, 8'h55, -1, 0, 32'h0005, 1, 1, 0);
      rd("ram_read_a005", 16'hA005, -1, 0, 32'h0005, 1, 0, 1);
      wr(16'h4000, 8'h03);
      wr(16'h6000, 8'h01);
      rd("ram_mode1_hi3", 16'hA005, -1, 0, 32'h6005, 1, 0, 1);
      rd("mode1_read_0000", 16'h0000, 32'h00000, 1, 32'h6000, 0, 0, 1);
      wr(16'h0000, 8'h1B);
      rd("ram_disabled_1b", 16'hA005, -1, 0, 32'h6005, 0, 0, 0);
      wr(16'h0000, 8'hFA);
      rd("ram_enabled_fa", 16'hBFFF, -1, 0, 32'h7FFF, 1, 0, 1);
      wr(16'hC000, 8'h00);
      wr(16'h8000, 8'h00);
      rd("high_writes_ignored", 16'hBFFF, -1, 0, 32'h7FFF, 1, 0, 1);
      rd("read_8000_no_cs", 16'h8000, -1, 0, 32'h6000, 0, 0, 0);

      // Held write: only the first edge counts even though data changes.
      bus.addr = 16'h2000;
      bus.data_w = 8'h03;
      bus.write_enable = 1'b1;
      step();
      bus.data_w = 8'h07;
      step();
      step();
      step();
      bus.write_enable = 1'b0;
      step();
      rd("held_write_once", 16'h4000, 32'h0C000, 1, 32'h6000, 0, 0, 1);

      // Reset asserted in the middle of a held write clears state without a clock edge.
      bus.addr = 16'h2000;
      bus.data_w = 8'h09;
      bus.write_enable = 1'b1;
      step();
      bus.data_w = 8'h0B;
      reset_n = 1'b0;
      expect_now("async_reset_mid_hold", 32'h02000, 0, 32'h0000, 0, 0, 0);
      step();
      reset_n = 1'b1;
      step();
      step();
      step();
      bus.write_enable = 1'b0;
      step();
      rd("held_across_reset_ignored", 16'h4000, 32'h04000, 1, 32'h0000, 0, 0, 1);
      rd("ram_off_after_reset", 16'hA000, -1, 0, 32'h0000, 0, 0, 0);
      wr(16'h2000, 8'h0B);
      rd("new_write_after_reset", 16'h4000, 32'h2C000, 1, 32'h0000, 0, 0, 1);

      step();
      step();
      tests++;
      if (sb.size() != 0) begin
         fails++;
         $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
